// File: rtl/subleq_mem_responder.sv
// Word store for the Subleq core: a byte-stream loader fills it after reset (LOAD), then the core owns it (RUN).
// Define SUBLEQ_MEM_WP_EN to drop RUN-state core writes below WP_LIMIT and flag them on wp_fault.
module subleq_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int WP_LIMIT   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  writeEnable,
  input  logic [31:0]           writeData,
  output logic [31:0]           readData,
  input  logic                  load_valid,
  input  logic [7:0]            load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  core_run,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [31:0]           dbg_data,
  output logic                  wp_fault
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Loader handshake: a byte moves on a rising edge where load_valid && load_ready.
  // load_ready is high for the whole LOAD state and low for the whole RUN state.
  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [31:0]             word_q, word_d;
  logic [31:0]             dbg_data_q, dbg_data_d;
  logic [31:0]             word_next;
  logic                    xfer;
  logic                    ld_we;
  logic                    core_we;
  logic [31:0]             mem [DEPTH];

  assign readData   = mem[addr];
  assign core_run   = (state_q == S_RUN);
  assign load_ready = (state_q == S_LOAD);
  assign dbg_data   = dbg_data_q;

  always_comb begin
    xfer       = (state_q == S_LOAD) && load_valid;
    // word_q only ever holds the bytes already received, upper lanes stay zero
    word_next  = word_q | ({24'd0, load_data} << {byte_cnt_q, 3'b000});
    ld_we      = xfer && ((byte_cnt_q == 2'd3) || load_last);
    state_d    = state_q;
    ptr_d      = ptr_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    dbg_data_d = mem[dbg_addr];
    if (xfer) begin
      if (ld_we) begin
        word_d     = '0;
        byte_cnt_d = 2'd0;
        if (ptr_q == LAST_ADDR) begin
          state_d = S_RUN;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
        if (load_last) begin
          state_d = S_RUN;
        end
      end else begin
        word_d     = word_next;
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
    end
  end

`ifdef SUBLEQ_MEM_WP_EN
  localparam logic [ADDR_WIDTH:0] WP_BOUND = (ADDR_WIDTH + 1)'(WP_LIMIT);
  logic wp_hit;
  logic wp_fault_q, wp_fault_d;

  always_comb begin
    wp_hit     = (state_q == S_RUN) && writeEnable && ({1'b0, addr} < WP_BOUND);
    core_we    = (state_q == S_RUN) && writeEnable && !wp_hit;
    wp_fault_d = wp_fault_q | wp_hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_fault_q <= 1'b0;
    end else begin
      wp_fault_q <= wp_fault_d;
    end
  end

  assign wp_fault = wp_fault_q;
`else
  always_comb begin
    core_we = (state_q == S_RUN) && writeEnable;
  end

  assign wp_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_LOAD;
      ptr_q      <= '0;
      byte_cnt_q <= 2'd0;
      word_q     <= '0;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  // Storage is deliberately outside the reset domain so an image survives a reset.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ptr_q] <= word_next;
    end else if (core_we) begin
      mem[addr] <= writeData;
    end
  end

endmodule

// File: tb/tb_subleq_mem_responder.sv
// Directed bench for subleq_mem_responder: loader packing, RUN writes, debug port, overflow, protection, reset.
module tb_subleq_mem_responder;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset;
  logic [AW-1:0] addr;
  logic          writeEnable;
  logic [31:0]   writeData;
  logic [31:0]   readData;
  logic          load_valid;
  logic [7:0]    load_data;
  logic          load_last;
  logic          load_ready;
  logic          core_run;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_data;
  logic          wp_fault;

  int checks = 0;
  int errors = 0;

  subleq_mem_responder #(.ADDR_WIDTH(AW), .WP_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .writeEnable(writeEnable),
    .writeData(writeData), .readData(readData), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .core_run(core_run), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wp_fault(wp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic core_write(input logic [AW-1:0] a, input logic [31:0] d);
    addr        = a;
    writeData   = d;
    writeEnable = 1'b1;
    tick();
    writeEnable = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    addr = '0; writeEnable = 1'b0; writeData = '0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0; dbg_addr = '0;
    tick();
    tick();
    checks++; if (core_run !== 1'b0) begin errors++; $display("FAIL reset_core_run: got %b expected 0", core_run); end
    checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL reset_dbg_data: got %h expected 00000000", dbg_data); end
    checks++; if (wp_fault !== 1'b0) begin errors++; $display("FAIL reset_wp_fault: got %b expected 0", wp_fault); end
    reset = 1'b1;
    tick();
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b expected 1", load_ready); end
  endtask

  task automatic test_basic_load();
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(i + 1), i == 7);
      if (i == 6) begin
        checks++; if (core_run !== 1'b0) begin errors++; $display("FAIL load8_early_run: got %b expected 0", core_run); end
      end
    end
    checks++; if (core_run !== 1'b1) begin errors++; $display("FAIL load8_core_run: got %b expected 1", core_run); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load8_load_ready: got %b expected 0", load_ready); end
    addr = 10'd0; #1;
    checks++; if (readData !== 32'h04030201) begin errors++; $display("FAIL load8_mem0: got %h expected 04030201", readData); end
    addr = 10'd1; #1;
    checks++; if (readData !== 32'h08070605) begin errors++; $display("FAIL load8_mem1: got %h expected 08070605", readData); end
  endtask

  task automatic test_partial_load();
    logic [7:0] b [5];
    b[0] = 8'hAA; b[1] = 8'hBB; b[2] = 8'hCC; b[3] = 8'hDD; b[4] = 8'hEE;
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(b[i], i == 4);
    checks++; if (core_run !== 1'b1) begin errors++; $display("FAIL partial_core_run: got %b expected 1", core_run); end
    addr = 10'd0; #1;
    checks++; if (readData !== 32'hDDCCBBAA) begin errors++; $display("FAIL partial_mem0: got %h expected ddccbbaa", readData); end
    addr = 10'd1; #1;
    checks++; if (readData !== 32'h000000EE) begin errors++; $display("FAIL partial_mem1: got %h expected 000000ee", readData); end
    send_byte(8'h77, 1'b1);
    addr = 10'd2; #1;
    checks++; if (readData === 32'h00000077) begin errors++; $display("FAIL run_ignores_loader: got %h expected not 00000077", readData); end
  endtask

  task automatic test_run_write();
    core_write(10'h3FF, 32'h11111111);
    core_write(10'd5, 32'h55AA55AA);
    addr = 10'h3FF; writeData = 32'hDEADBEEF; writeEnable = 1'b1; dbg_addr = 10'h3FF; #1;
    checks++; if (readData !== 32'h11111111) begin errors++; $display("FAIL rdw_old: got %h expected 11111111", readData); end
    tick();
    writeEnable = 1'b0;
    checks++; if (readData !== 32'hDEADBEEF) begin errors++; $display("FAIL rdw_new: got %h expected deadbeef", readData); end
    checks++; if (dbg_data !== 32'h11111111) begin errors++; $display("FAIL dbg_same_edge: got %h expected 11111111", dbg_data); end
    tick();
    checks++; if (dbg_data !== 32'hDEADBEEF) begin errors++; $display("FAIL dbg_next: got %h expected deadbeef", dbg_data); end
    dbg_addr = 10'd5;
    tick();
    checks++; if (dbg_data !== 32'h55AA55AA) begin errors++; $display("FAIL dbg_addr5: got %h expected 55aa55aa", dbg_data); end
  endtask

  task automatic test_gap_load();
    do_reset();
    addr = 10'd5; writeData = 32'hFFFFFFFF; writeEnable = 1'b1;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    tick(); tick(); tick();
    writeEnable = 1'b0;
    checks++; if (readData !== 32'h55AA55AA) begin errors++; $display("FAIL load_ignores_core: got %h expected 55aa55aa", readData); end
    addr = 10'd0; #1;
    checks++; if (readData !== 32'hDDCCBBAA) begin errors++; $display("FAIL gap_no_write: got %h expected ddccbbaa", readData); end
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b1);
    checks++; if (readData !== 32'h44332211) begin errors++; $display("FAIL gap_mem0: got %h expected 44332211", readData); end
    addr = 10'd1; #1;
    checks++; if (readData !== 32'h00000055) begin errors++; $display("FAIL gap_mem1: got %h expected 00000055", readData); end
  endtask

  task automatic test_overflow();
    int w;
    do_reset();
    for (int k = 0; k < 4 * DEPTH; k++) begin
      w = k / 4;
      send_byte(8'(w >> (8 * (k % 4))), 1'b0);
      if (k == 4 * DEPTH - 2) begin
        checks++; if (core_run !== 1'b0) begin errors++; $display("FAIL ovf_early_run: got %b expected 0", core_run); end
      end
    end
    checks++; if (core_run !== 1'b1) begin errors++; $display("FAIL ovf_core_run: got %b expected 1", core_run); end
    load_valid = 1'b1; load_data = 8'hFF; load_last = 1'b0; #1;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL ovf_load_ready: got %b expected 0", load_ready); end
    tick();
    load_valid = 1'b0;
    addr = 10'h3FF; #1;
    checks++; if (readData !== 32'h000003FF) begin errors++; $display("FAIL ovf_mem_last: got %h expected 000003ff", readData); end
    addr = 10'd0; #1;
    checks++; if (readData !== 32'h00000000) begin errors++; $display("FAIL ovf_mem0: got %h expected 00000000", readData); end
    addr = 10'd512; #1;
    checks++; if (readData !== 32'h00000200) begin errors++; $display("FAIL ovf_mem512: got %h expected 00000200", readData); end
  endtask

  task automatic test_write_protect();
    core_write(10'd2, 32'h00000001);
    core_write(10'd4, 32'h00000044);
    addr = 10'd2; #1;
`ifdef SUBLEQ_MEM_WP_EN
    checks++; if (readData !== 32'h00000002) begin errors++; $display("FAIL wp_mem2: got %h expected 00000002", readData); end
    checks++; if (wp_fault !== 1'b1) begin errors++; $display("FAIL wp_fault_set: got %b expected 1", wp_fault); end
`else
    checks++; if (readData !== 32'h00000001) begin errors++; $display("FAIL wp_mem2: got %h expected 00000001", readData); end
    checks++; if (wp_fault !== 1'b0) begin errors++; $display("FAIL wp_fault_tied: got %b expected 0", wp_fault); end
`endif
    addr = 10'd4; #1;
    checks++; if (readData !== 32'h00000044) begin errors++; $display("FAIL wp_mem4: got %h expected 00000044", readData); end
    tick();
    do_reset();
    checks++; if (wp_fault !== 1'b0) begin errors++; $display("FAIL wp_fault_cleared: got %b expected 0", wp_fault); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h01, 1'b1);
    checks++; if (core_run !== 1'b1) begin errors++; $display("FAIL mid_run_entry: got %b expected 1", core_run); end
    reset = 1'b0; #1;
    checks++; if (core_run !== 1'b0) begin errors++; $display("FAIL mid_run_async: got %b expected 0", core_run); end
    tick();
    reset = 1'b1;
    tick();
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b0);
    reset = 1'b0; #1;
    checks++; if (core_run !== 1'b0) begin errors++; $display("FAIL mid_load_run: got %b expected 0", core_run); end
    tick();
    reset = 1'b1;
    tick();
    send_byte(8'h9A, 1'b0);
    send_byte(8'hBC, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hF0, 1'b1);
    addr = 10'd0; #1;
    checks++; if (readData !== 32'hF0DEBC9A) begin errors++; $display("FAIL mid_load_restart: got %h expected f0debc9a", readData); end
    checks++; if (core_run !== 1'b1) begin errors++; $display("FAIL mid_load_done: got %b expected 1", core_run); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_partial_load();
    test_run_write();
    test_gap_load();
    test_overflow();
    test_write_protect();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
